// File: rtl/frontier_queue_ctrl.sv
// Frontier-queue sequencer: unsorted packed array spread over three single-port RAMs,
// linear-scan PUSH-with-relax and POP_MIN with last-entry compaction.
module frontier_queue_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_vertex,
  input  logic [DATA_W-1:0] cmd_prev,
  input  logic [DATA_W-1:0] cmd_dist,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_vertex,
  output logic [DATA_W-1:0] rsp_prev,
  output logic [DATA_W-1:0] rsp_dist,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_vertex_d,
  output logic [DATA_W-1:0] mem_prev_d,
  output logic [DATA_W-1:0] mem_dist_d,
  input  logic [DATA_W-1:0] mem_vertex_q,
  input  logic [DATA_W-1:0] mem_prev_q,
  input  logic [DATA_W-1:0] mem_dist_q,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic [2:0]        dbg_state
);

  // Handshake: a command is taken on any cycle with cmd_valid && cmd_ready (IDLE only);
  // exactly one single-cycle rsp_valid pulse follows, and it cannot be stalled.

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] PUSH_SCAN  = 3'd1;
  localparam logic [2:0] PUSH_WR    = 3'd2;
  localparam logic [2:0] POP_SCAN   = 3'd3;
  localparam logic [2:0] POP_RDLAST = 3'd4;
  localparam logic [2:0] POP_WR     = 3'd5;
  localparam logic [2:0] RESP       = 3'd6;

  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_EMPTY   = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;
  localparam logic [1:0] ST_DROPPED = 2'b11;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [2:0]        state;
  logic [ADDR_W:0]   count_r;
  logic [DATA_W-1:0] v_r, p_r, d_r;
  logic [ADDR_W:0]   scan_idx;
  logic              cmp_vld;
  logic [ADDR_W:0]   cmp_idx;
  logic [ADDR_W:0]   wr_idx;
  logic              push_append;
  logic              have_min;
  logic [DATA_W-1:0] min_v, min_p, min_d;
  logic [ADDR_W:0]   min_idx;
  logic [1:0]        status_r;
  logic              rsp_data_r;

  logic              issuing;
  logic              last_cmp;
  logic              take;
  logic [ADDR_W:0]   last_idx;
  logic [ADDR_W:0]   nxt_min_idx;

  assign last_idx    = count_r - 1'b1;
  assign issuing     = (scan_idx < count_r);
  assign last_cmp    = cmp_vld && (cmp_idx == last_idx);
  // Strict less-than keeps the earliest index on equal distances.
  assign take        = cmp_vld && (!have_min || (mem_dist_q < min_d));
  assign nxt_min_idx = take ? cmp_idx : min_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count_r     <= '0;
      v_r         <= '0;
      p_r         <= '0;
      d_r         <= '0;
      scan_idx    <= '0;
      cmp_vld     <= 1'b0;
      cmp_idx     <= '0;
      wr_idx      <= '0;
      push_append <= 1'b0;
      have_min    <= 1'b0;
      min_v       <= '0;
      min_p       <= '0;
      min_d       <= '0;
      min_idx     <= '0;
      status_r    <= ST_OK;
      rsp_data_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            v_r        <= cmd_vertex;
            p_r        <= cmd_prev;
            d_r        <= cmd_dist;
            scan_idx   <= '0;
            cmp_vld    <= 1'b0;
            have_min   <= 1'b0;
            status_r   <= ST_OK;
            rsp_data_r <= 1'b0;
            case (cmd_op)
              OP_PUSH: begin
                if (count_r == '0) begin
                  wr_idx      <= '0;
                  push_append <= 1'b1;
                  state       <= PUSH_WR;
                end else begin
                  state <= PUSH_SCAN;
                end
              end
              OP_POP: begin
                if (count_r == '0) begin
                  status_r <= ST_EMPTY;
                  state    <= RESP;
                end else begin
                  state <= POP_SCAN;
                end
              end
              OP_CLEAR: begin
                count_r <= '0;
                state   <= RESP;
              end
              default: state <= RESP;
            endcase
          end
        end
        PUSH_SCAN: begin
          if (issuing) scan_idx <= scan_idx + 1'b1;
          cmp_vld <= issuing;
          cmp_idx <= scan_idx;
          if (cmp_vld && (mem_vertex_q == v_r)) begin
            if (d_r < mem_dist_q) begin
              wr_idx      <= cmp_idx;
              push_append <= 1'b0;
              state       <= PUSH_WR;
            end else begin
              status_r <= ST_DROPPED;
              state    <= RESP;
            end
          end else if (last_cmp) begin
            if (count_r < DEPTH_C) begin
              wr_idx      <= count_r;
              push_append <= 1'b1;
              state       <= PUSH_WR;
            end else begin
              status_r <= ST_FULL;
              state    <= RESP;
            end
          end
        end
        PUSH_WR: begin
          count_r <= count_r + {{ADDR_W{1'b0}}, push_append};
          state   <= RESP;
        end
        POP_SCAN: begin
          if (issuing) scan_idx <= scan_idx + 1'b1;
          cmp_vld <= issuing;
          cmp_idx <= scan_idx;
          if (take) begin
            have_min <= 1'b1;
            min_v    <= mem_vertex_q;
            min_p    <= mem_prev_q;
            min_d    <= mem_dist_q;
            min_idx  <= cmp_idx;
          end
          if (last_cmp) begin
            wr_idx     <= nxt_min_idx;
            rsp_data_r <= 1'b1;
            if (nxt_min_idx == last_idx) begin
              count_r <= last_idx;
              state   <= RESP;
            end else begin
              state <= POP_RDLAST;
            end
          end
        end
        POP_RDLAST: state <= POP_WR;
        POP_WR: begin
          count_r <= last_idx;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign rsp_status = rsp_valid ? status_r : ST_OK;
  assign rsp_vertex = (rsp_valid && rsp_data_r) ? min_v : '0;
  assign rsp_prev   = (rsp_valid && rsp_data_r) ? min_p : '0;
  assign rsp_dist   = (rsp_valid && rsp_data_r) ? min_d : '0;

  // POP_WR forwards the RAM output directly: it holds entry count-1 read in POP_RDLAST.
  always_comb begin
    mem_addr     = '0;
    mem_wren     = 1'b0;
    mem_vertex_d = '0;
    mem_prev_d   = '0;
    mem_dist_d   = '0;
    case (state)
      PUSH_SCAN, POP_SCAN: mem_addr = scan_idx[ADDR_W-1:0];
      POP_RDLAST:          mem_addr = last_idx[ADDR_W-1:0];
      PUSH_WR: begin
        mem_addr     = wr_idx[ADDR_W-1:0];
        mem_wren     = 1'b1;
        mem_vertex_d = v_r;
        mem_prev_d   = p_r;
        mem_dist_d   = d_r;
      end
      POP_WR: begin
        mem_addr     = wr_idx[ADDR_W-1:0];
        mem_wren     = 1'b1;
        mem_vertex_d = mem_vertex_q;
        mem_prev_d   = mem_prev_q;
        mem_dist_d   = mem_dist_q;
      end
      default: ;
    endcase
  end

  assign count     = count_r;
  assign empty     = (count_r == '0);
  assign full      = (count_r == DEPTH_C);
  assign dbg_state = state;

endmodule

// File: tb/tb_frontier_queue_ctrl.sv
// Bench for frontier_queue_ctrl (DEPTH=4 build): behavioural queue model, RAM model,
// per-response checker and directed/random command sequences.
module tb_frontier_queue_ctrl;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_vertex = '0, cmd_prev = '0, cmd_dist = '0;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic [DW-1:0] rsp_vertex, rsp_prev, rsp_dist;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_vertex_d, mem_prev_d, mem_dist_d;
  logic [DW-1:0] mem_vertex_q, mem_prev_q, mem_dist_q;
  logic [AW:0]   count;
  logic          empty, full;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  frontier_queue_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_vertex(cmd_vertex), .cmd_prev(cmd_prev), .cmd_dist(cmd_dist),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_vertex(rsp_vertex), .rsp_prev(rsp_prev), .rsp_dist(rsp_dist),
    .mem_addr(mem_addr), .mem_wren(mem_wren),
    .mem_vertex_d(mem_vertex_d), .mem_prev_d(mem_prev_d), .mem_dist_d(mem_dist_d),
    .mem_vertex_q(mem_vertex_q), .mem_prev_q(mem_prev_q), .mem_dist_q(mem_dist_q),
    .count(count), .empty(empty), .full(full), .dbg_state(dbg_state)
  );

  // Three synchronous single-port RAMs, read-first, one cycle read latency.
  logic [DW-1:0] vmem [DEPTH];
  logic [DW-1:0] pmem [DEPTH];
  logic [DW-1:0] dmem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) begin vmem[i] = '0; pmem[i] = '0; dmem[i] = '0; end
  always @(posedge clk) begin
    if (mem_wren) begin
      vmem[mem_addr] <= mem_vertex_d;
      pmem[mem_addr] <= mem_prev_d;
      dmem[mem_addr] <= mem_dist_d;
    end
    mem_vertex_q <= vmem[mem_addr];
    mem_prev_q   <= pmem[mem_addr];
    mem_dist_q   <= dmem[mem_addr];
  end

  localparam logic [1:0] OP_NOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_CLEAR = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_EMPTY = 2'b01, ST_FULL = 2'b10, ST_DROPPED = 2'b11;

  typedef struct packed { logic [DW-1:0] v, p, d; } ent_t;
  typedef struct packed {
    logic [1:0]    st;
    logic [DW-1:0] v, p, d;
    logic [AW:0]   cnt;
    logic [1:0]    nwr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wv, wp, wd;
    logic [31:0]   acc;
    logic [31:0]   bound;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int            wr_seen = 0;
  logic [AW-1:0] wa_seen;
  logic [DW-1:0] wv_seen, wp_seen, wd_seen;
  logic [1:0]    last_st;
  logic [DW-1:0] last_v, last_p, last_d;
  int            last_wr = 0;
  int            last_lat = 0;
  logic [AW-1:0] last_wa;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Queue semantics: unsorted array, relax-in-place on vertex hit, append otherwise,
  // POP_MIN takes the lowest-index minimum and moves the last entry into its slot.
  task automatic model_cmd(input logic [1:0] op, input logic [DW-1:0] v, p, d, input int acc);
    exp_t e;
    int n, idx, m;
    e = '0;
    e.acc = acc;
    n = mq.size();
    e.bound = 2;
    case (op)
      OP_PUSH: begin
        e.bound = n + 4;
        idx = -1;
        for (int i = 0; i < n; i++) if (mq[i].v == v) idx = i;
        if (idx >= 0) begin
          if (d < mq[idx].d) begin
            mq[idx] = '{v: v, p: p, d: d};
            e.st = ST_OK; e.nwr = 1; e.wa = AW'(idx);
            e.wv = v; e.wp = p; e.wd = d;
          end else begin
            e.st = ST_DROPPED;
          end
        end else if (n < DEPTH) begin
          mq.push_back('{v: v, p: p, d: d});
          e.st = ST_OK; e.nwr = 1; e.wa = AW'(n);
          e.wv = v; e.wp = p; e.wd = d;
        end else begin
          e.st = ST_FULL;
        end
      end
      OP_POP: begin
        if (n == 0) begin
          e.st = ST_EMPTY;
        end else begin
          e.bound = n + 6;
          m = 0;
          for (int i = 1; i < n; i++) if (mq[i].d < mq[m].d) m = i;
          e.st = ST_OK;
          e.v = mq[m].v; e.p = mq[m].p; e.d = mq[m].d;
          if (m != n - 1) begin
            e.nwr = 1; e.wa = AW'(m);
            e.wv = mq[n-1].v; e.wp = mq[n-1].p; e.wd = mq[n-1].d;
            mq[m] = mq[n-1];
          end
          void'(mq.pop_back());
        end
      end
      OP_CLEAR: begin
        mq.delete();
        e.st = ST_OK;
      end
      default: e.st = ST_OK;
    endcase
    e.cnt = (AW+1)'(mq.size());
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Checker: observes writes and compares every response against the model.
  initial forever begin
    exp_t e;
    int lat;
    @(negedge clk);
    if (rst_n) begin
      if (mem_wren) begin
        wr_seen++;
        wa_seen = mem_addr;
        wv_seen = mem_vertex_d; wp_seen = mem_prev_d; wd_seen = mem_dist_d;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_rsp");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_status", rsp_status, e.st);
          chk("rsp_vertex", rsp_vertex, e.v);
          chk("rsp_prev", rsp_prev, e.p);
          chk("rsp_dist", rsp_dist, e.d);
          chk("count", count, e.cnt);
          chk("empty", empty, e.cnt == 0);
          chk("full", full, e.cnt == DEPTH);
          chk("write_count", wr_seen, e.nwr);
          if (e.nwr != 0) begin
            chk("write_addr", wa_seen, e.wa);
            chk("write_vertex", wv_seen, e.wv);
            chk("write_prev", wp_seen, e.wp);
            chk("write_dist", wd_seen, e.wd);
          end
          lat = cyc - int'(e.acc);
          vectors++;
          if (lat > int'(e.bound) || lat < 1) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, bound %0d", lat, e.bound);
          end
          last_st = rsp_status; last_v = rsp_vertex; last_p = rsp_prev; last_d = rsp_dist;
          last_wr = wr_seen; last_wa = wa_seen; last_lat = lat;
        end
        wr_seen = 0;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [DW-1:0] v, p, d);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      flag("ready_timeout");
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_vertex = v; cmd_prev = p; cmd_dist = d;
    model_cmd(op, v, p, d, cyc);
    @(negedge clk);
    // Scramble the payload after acceptance; the controller must have latched it.
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_vertex = DW'($urandom); cmd_prev = DW'($urandom); cmd_dist = DW'($urandom);
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      flag("rsp_timeout");
      exp_q.delete();
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] v, p, d);
    send(op, v, p, d);
    wait_rsp();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_mem_wren", mem_wren, 0);
    chk("reset_mem_addr", mem_addr, 0);
    rst_n = 1'b1;

    // Basic push / pop ordering.
    do_cmd(OP_PUSH, 5, 1, 40);
    do_cmd(OP_PUSH, 7, 1, 10);
    do_cmd(OP_PUSH, 9, 5, 25);
    chk("t1_count3", count, 3);
    do_cmd(OP_POP, 0, 0, 0);
    chk("t1_pop1_v", last_v, 7); chk("t1_pop1_p", last_p, 1); chk("t1_pop1_d", last_d, 10);
    chk("t1_pop1_count", count, 2);
    do_cmd(OP_POP, 0, 0, 0);
    chk("t1_pop2_v", last_v, 9); chk("t1_pop2_p", last_p, 5); chk("t1_pop2_d", last_d, 25);
    do_cmd(OP_POP, 0, 0, 0);
    chk("t1_pop3_v", last_v, 5); chk("t1_pop3_d", last_d, 40);
    do_cmd(OP_POP, 0, 0, 0);
    chk("t1_pop_empty_st", last_st, ST_EMPTY); chk("t1_pop_empty_cnt", count, 0);

    // Relax and drop.
    do_cmd(OP_PUSH, 5, 1, 40);
    do_cmd(OP_PUSH, 5, 3, 30);
    chk("t2_relax_st", last_st, ST_OK); chk("t2_relax_cnt", count, 1);
    do_cmd(OP_PUSH, 5, 4, 50);
    chk("t2_drop_st", last_st, ST_DROPPED); chk("t2_drop_wr", last_wr, 0);
    do_cmd(OP_POP, 0, 0, 0);
    chk("t2_pop_v", last_v, 5); chk("t2_pop_p", last_p, 3); chk("t2_pop_d", last_d, 30);

    // Full queue.
    for (int i = 1; i <= 4; i++) do_cmd(OP_PUSH, DW'(i), 0, DW'(10 * i));
    chk("t3_full", full, 1);
    do_cmd(OP_PUSH, 6, 0, 5);
    chk("t3_full_st", last_st, ST_FULL); chk("t3_full_cnt", count, 4);
    do_cmd(OP_PUSH, 3, 2, 15);
    chk("t3_relax_full_st", last_st, ST_OK); chk("t3_relax_full_cnt", count, 4);
    do_cmd(OP_CLEAR, 0, 0, 0);

    // Tie on distance: lowest index wins, last entry compacted into index 0.
    do_cmd(OP_PUSH, 1, 0, 20);
    do_cmd(OP_PUSH, 2, 0, 30);
    do_cmd(OP_PUSH, 3, 0, 20);
    do_cmd(OP_POP, 0, 0, 0);
    chk("t4_tie_v", last_v, 1); chk("t4_tie_d", last_d, 20);
    chk("t4_tie_wr", last_wr, 1); chk("t4_tie_wa", last_wa, 0); chk("t4_tie_cnt", count, 2);

    // CLEAR with three entries.
    do_cmd(OP_PUSH, 4, 0, 50);
    chk("t5_pre_cnt", count, 3);
    do_cmd(OP_CLEAR, 0, 0, 0);
    chk("t5_clear_lat_le2", last_lat <= 2, 1); chk("t5_clear_empty", empty, 1);

    // Reset in the middle of a POP scan.
    do_cmd(OP_PUSH, 1, 0, 9);
    do_cmd(OP_PUSH, 2, 0, 8);
    do_cmd(OP_PUSH, 3, 0, 7);
    send(OP_POP, 0, 0, 0);
    rst_n = 1'b0;
    exp_q.delete();
    mq.delete();
    wr_seen = 0;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_post_cmd_ready", cmd_ready, 1);
    chk("t6_post_count", count, 0);

    // Random command mix against the model.
    for (int k = 0; k < 1000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      do_cmd(OP_PUSH, DW'($urandom_range(0, 5)), DW'($urandom_range(0, 255)), DW'($urandom_range(0, 63)));
      else if (r < 85) do_cmd(OP_POP, 0, 0, 0);
      else if (r < 90) do_cmd(OP_CLEAR, 0, 0, 0);
      else             do_cmd(OP_NOP, DW'($urandom), DW'($urandom), DW'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
